filter_spad_ctrl: RTL and testbench



---
 rtl/eyeriss_pe_pkg.sv | 16 +
 rtl/wrap_counter.sv | 24 ++
 rtl/filter_spad_ctrl.sv | 132 +++++++++++++
 tb/tb_filter_spad_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eyeriss_pe_pkg.sv
// Shared PE definitions: datapath widths, filter spad geometry and the
// filter scratch-pad controller state encoding.
package eyeriss_pe_pkg;

  localparam int DATA_W           = 16;
  localparam int FILT_SPAD_DEPTH  = 224;
  localparam int FILT_SPAD_ADDR_W = 8;

  typedef enum logic [1:0] {
    FILT_IDLE   = 2'd0,
    FILT_LOAD   = 2'd1,
    FILT_STREAM = 2'd2,
    FILT_DONE   = 2'd3
  } filt_state_e;

endpackage

// File: rtl/wrap_counter.sv
// Pointer counter with synchronous load, enable, and wrap to zero after
// reaching a runtime limit; `wrap` flags that the current value is the limit.
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (en)  cnt <= wrap ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/filter_spad_ctrl.sv
// Filter scratch-pad controller: loads a filter from the input stream and
// replays it to the MAC num_reps times. Optional FILT_ZERO_GATE_EN builds out_zero.
import eyeriss_pe_pkg::*;

module filter_spad_ctrl #(
  parameter int DATA_W = eyeriss_pe_pkg::DATA_W,
  parameter int ADDR_W = eyeriss_pe_pkg::FILT_SPAD_ADDR_W,
  parameter int DEPTH  = eyeriss_pe_pkg::FILT_SPAD_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              reload,
  input  logic [ADDR_W-1:0] filt_len,
  input  logic [7:0]        num_reps,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_zero,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] spad_addr,
  output logic              spad_we,
  output logic [DATA_W-1:0] spad_wdata,
  input  logic [DATA_W-1:0] spad_rdata
);

  filt_state_e state_q, state_d;

  logic [ADDR_W-1:0] len_q, len_m1, len_sat, wr_ptr, rd_ptr;
  logic [7:0]        reps_q, rep_cnt;
  logic              cmd_go, wr_en, rd_en, wr_last, rd_last;

  assign cmd_go  = start && (state_q == FILT_IDLE);
  assign len_sat = (filt_len > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : filt_len;
  assign len_m1  = len_q - ADDR_W'(1);
  assign wr_en   = (state_q == FILT_LOAD) && in_valid;
  assign rd_en   = (state_q == FILT_STREAM) && out_ready;

  // Both pointers restart at zero on every accepted command.
  wrap_counter #(.W(ADDR_W)) u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (cmd_go),
    .ld_val ('0),
    .en     (wr_en),
    .limit  (len_m1),
    .cnt    (wr_ptr),
    .wrap   (wr_last)
  );

  wrap_counter #(.W(ADDR_W)) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (cmd_go),
    .ld_val ('0),
    .en     (rd_en),
    .limit  (len_m1),
    .cnt    (rd_ptr),
    .wrap   (rd_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILT_IDLE;
      len_q   <= '0;
      reps_q  <= '0;
      rep_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_go) begin
        len_q  <= len_sat;
        reps_q <= num_reps;
      end
      if (state_q == FILT_DONE)    rep_cnt <= '0;
      else if (rd_en && rd_last)   rep_cnt <= rep_cnt + 8'd1;
    end
  end

  // Spad controls are combinational off posedge state so a write issued in
  // a cycle lands at that cycle's negedge.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = (state_q != FILT_IDLE);
    done       = 1'b0;
    spad_addr  = '0;
    spad_we    = 1'b0;
    spad_wdata = '0;
    unique case (state_q)
      FILT_IDLE: begin
        if (start) begin
          if (len_sat == '0 || num_reps == 8'd0) state_d = FILT_DONE;
          else if (reload)                       state_d = FILT_LOAD;
          else                                   state_d = FILT_STREAM;
        end
      end
      FILT_LOAD: begin
        in_ready   = 1'b1;
        spad_addr  = wr_ptr;
        spad_wdata = in_data;
        spad_we    = in_valid;
        if (wr_en && wr_last) state_d = FILT_STREAM;
      end
      FILT_STREAM: begin
        spad_addr = rd_ptr;
        out_valid = 1'b1;
        out_last  = rd_last;
        if (rd_en && rd_last && rep_cnt == reps_q - 8'd1) state_d = FILT_DONE;
      end
      FILT_DONE: begin
        done    = 1'b1;
        state_d = FILT_IDLE;
      end
    endcase
  end

  assign out_data = spad_rdata;

`ifdef FILT_ZERO_GATE_EN
  assign out_zero = out_valid && (out_data == '0);
`else
  assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_filter_spad_ctrl.sv
// Directed bench for filter_spad_ctrl with a negedge-clocked spad model.
module tb_filter_spad_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;
`ifdef FILT_ZERO_GATE_EN
  localparam logic ZG = 1'b1;
`else
  localparam logic ZG = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, reload = 1'b0;
  logic [AW-1:0] filt_len = '0;
  logic [7:0]    num_reps = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready = 1'b0, out_last, out_zero, busy, done;
  logic [AW-1:0] spad_addr;
  logic          spad_we;
  logic [DW-1:0] spad_wdata, spad_rdata;
  logic [DW-1:0] mem [0:223];

  filter_spad_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reload(reload),
    .filt_len(filt_len), .num_reps(num_reps),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_zero(out_zero), .busy(busy), .done(done),
    .spad_addr(spad_addr), .spad_we(spad_we), .spad_wdata(spad_wdata),
    .spad_rdata(spad_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spad_we) mem[spad_addr] <= spad_wdata;
    else         spad_rdata     <= mem[spad_addr];
  end

  int n_vec = 0, n_err = 0;
  logic [DW-1:0] ld_vec[$], exp_d[$], got_d[$], wr_d[$];
  logic          rdy_pat[$], exp_l[$], got_l[$], got_z[$];
  logic [AW-1:0] wr_a[$];
  int n_done, n_busy, n_valid, n_inrdy, first_vld, done_cyc, cyc, vcyc;
  logic          stalled;
  logic [DW-1:0] stall_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    ld_vec.delete(); exp_d.delete(); exp_l.delete(); rdy_pat.delete();
    got_d.delete(); got_l.delete(); got_z.delete(); wr_a.delete(); wr_d.delete();
    n_done = 0; n_busy = 0; n_valid = 0; n_inrdy = 0;
    first_vld = -1; done_cyc = -1; cyc = 0; vcyc = 0; stalled = 1'b0; stall_d = '0;
  endtask

  // Called just before the posedge that commits this cycle's handshakes.
  task automatic sample();
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy) n_busy++;
    if (in_ready) n_inrdy++;
    if (spad_we) begin wr_a.push_back(spad_addr); wr_d.push_back(spad_wdata); end
    if (out_valid) begin
      n_valid++;
      if (first_vld < 0) first_vld = cyc;
      if (stalled) chk("stall_hold", out_data, stall_d);
      stalled = !out_ready;
      stall_d = out_data;
      if (out_ready) begin
        got_d.push_back(out_data); got_l.push_back(out_last); got_z.push_back(out_zero);
      end
      vcyc++;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    start     = 1'b0;
    in_valid  = (ld_vec.size() > wr_a.size());
    in_data   = in_valid ? ld_vec[wr_a.size()] : '0;
    out_ready = (vcyc < rdy_pat.size()) ? rdy_pat[vcyc] : 1'b1;
    #8; sample();
  endtask

  task automatic cmd(input logic rl, input int len, input int reps);
    @(posedge clk); #1;
    start = 1'b1; reload = rl; filt_len = AW'(len); num_reps = 8'(reps);
    in_valid = 1'b0; out_ready = 1'b1;
    #8; sample();
  endtask

  task automatic run(input string tag, input int bound);
    int k = 0;
    while (n_done == 0 && k < bound) begin step(); k++; end
    chk({tag, "_timeout"}, (n_done == 0), 0);
    step();
    chk({tag, "_idle_after"}, busy, 0);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk({tag, "_data"}, got_d[i], exp_d[i]);
      chk({tag, "_last"}, got_l[i], exp_l[i]);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_zero"}, out_zero, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_spad_we"}, spad_we, 0);
    chk({tag, "_spad_addr"}, spad_addr, 0);
    chk({tag, "_spad_wdata"}, spad_wdata, 0);
  endtask

  initial begin
    int bad, nl;
    clear_logs();
    #3 chk_reset_outs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // Load 5,7,9 and replay twice.
    clear_logs();
    ld_vec = '{16'd5, 16'd7, 16'd9};
    exp_d  = '{16'd5, 16'd7, 16'd9, 16'd5, 16'd7, 16'd9};
    exp_l  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cmd(1'b1, 3, 2); run("t1", 40);
    chk("t1_wr_count", wr_a.size(), 3);
    for (int i = 0; i < wr_a.size() && i < 3; i++) begin
      chk("t1_wr_addr", wr_a[i], i);
      chk("t1_wr_data", wr_d[i], ld_vec[i]);
    end
    check_stream("t1");
    chk("t1_in_ready_cycles", n_inrdy, 3);
    chk("t1_first_valid", first_vld, 4);
    chk("t1_done_cycle", done_cyc, 10);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_busy_cycles", n_busy, 10);

    // Same load with out_ready 1,0,0,1 at the start of the stream.
    clear_logs();
    ld_vec  = '{16'd5, 16'd7, 16'd9};
    exp_d   = '{16'd5, 16'd7, 16'd9, 16'd5, 16'd7, 16'd9};
    exp_l   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cmd(1'b1, 3, 2); run("t2", 40);
    check_stream("t2");
    chk("t2_valid_cycles", n_valid, 8);
    chk("t2_done_cycle", done_cyc, 12);

    // Reuse of the stored filter.
    clear_logs();
    exp_d = '{16'd5, 16'd7, 16'd9};
    exp_l = '{1'b0, 1'b0, 1'b1};
    cmd(1'b0, 3, 1); run("t3", 20);
    check_stream("t3");
    chk("t3_in_ready_cycles", n_inrdy, 0);
    chk("t3_wr_count", wr_a.size(), 0);
    chk("t3_first_valid", first_vld, 1);
    chk("t3_done_pulses", n_done, 1);

    // Degenerate commands complete immediately.
    clear_logs();
    cmd(1'b1, 0, 3); run("t4a", 10);
    chk("t4a_busy_cycles", n_busy, 1);
    chk("t4a_done_cycle", done_cyc, 1);
    chk("t4a_wr_count", wr_a.size(), 0);
    chk("t4a_valid_cycles", n_valid, 0);
    clear_logs();
    cmd(1'b0, 3, 0); run("t4b", 10);
    chk("t4b_busy_cycles", n_busy, 1);
    chk("t4b_done_pulses", n_done, 1);
    chk("t4b_valid_cycles", n_valid, 0);

    // Oversized filter saturates to 224 entries; two passes show the wrap.
    clear_logs();
    for (int i = 0; i < 250; i++) ld_vec.push_back(16'h1000 + 16'(i));
    cmd(1'b1, 250, 2); run("t5", 1200);
    chk("t5_wr_count", wr_a.size(), 224);
    bad = 0;
    for (int i = 0; i < wr_a.size() && i < 224; i++)
      if (wr_a[i] !== AW'(i) || wr_d[i] !== ld_vec[i]) bad++;
    chk("t5_wr_seq_bad", bad, 0);
    chk("t5_out_count", got_d.size(), 448);
    bad = 0; nl = 0;
    for (int i = 0; i < got_d.size() && i < 448; i++) begin
      if (got_d[i] !== 16'h1000 + 16'(i % 224)) bad++;
      if (got_l[i]) nl++;
    end
    chk("t5_out_seq_bad", bad, 0);
    chk("t5_last_count", nl, 2);
    if (got_l.size() == 448) begin
      chk("t5_last_223", got_l[223], 1);
      chk("t5_wrap_first", got_d[224], 16'h1000);
    end

    // Zero-weight flag.
    clear_logs();
    ld_vec = '{16'd0, 16'd3};
    exp_d  = '{16'd0, 16'd3};
    exp_l  = '{1'b0, 1'b1};
    cmd(1'b1, 2, 1); run("t6", 20);
    check_stream("t6");
    if (got_z.size() == 2) begin
      chk("t6_zero_w0", got_z[0], ZG);
      chk("t6_zero_w1", got_z[1], 0);
    end else chk("t6_zero_count", got_z.size(), 2);

    // Reset mid-stream aborts with no done pulse.
    clear_logs();
    cmd(1'b0, 2, 5);
    for (int i = 0; i < 3; i++) step();
    chk("t7_streaming", out_valid, 1);
    #2 rst_n = 1'b0;
    #2 chk_reset_outs("t7_rst");
    #1 rst_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) step();
    chk("t7_no_done", n_done, 0);
    chk("t7_no_busy", n_busy, 0);
    chk("t7_no_valid", n_valid, 0);

    // Controller recovers and still replays the retained filter.
    clear_logs();
    exp_d = '{16'd0, 16'd3};
    exp_l = '{1'b0, 1'b1};
    cmd(1'b0, 2, 1); run("t8", 20);
    check_stream("t8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
